// File: rtl/cp0_unit.sv
// Coprocessor-0 register bank and exception sequencer: Count/Compare timer,
// Status, Cause, EPC, MFC0 read mux and fetch redirect on interrupt/syscall/eret.
module cp0_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        CP0RE,
  input  logic [4:0]  CP0RAddr,
  input  logic        CP0WE,
  input  logic [4:0]  CP0WAddr,
  input  logic [31:0] WData,
  input  logic        ExcSyscall,
  input  logic        ExcEret,
  input  logic [31:0] PC,
  input  logic [5:0]  IntIn,
  output logic [31:0] RData,
  output logic        ExcTaken,
  output logic [31:0] ExcPC,
  output logic [31:0] StatusOut,
  output logic [31:0] CauseOut,
  output logic [31:0] EPCOut,
  output logic        TimerInt
);

  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam logic [4:0]  REG_COUNT    = 5'd9;
  localparam logic [4:0]  REG_COMPARE  = 5'd11;
  localparam logic [4:0]  REG_STATUS   = 5'd12;
  localparam logic [4:0]  REG_CAUSE    = 5'd13;
  localparam logic [4:0]  REG_EPC      = 5'd14;
  localparam logic [4:0]  EXC_SYSCALL  = 5'd8;
  localparam logic [4:0]  EXC_INT      = 5'd0;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_q, timer_d;

  logic [31:0] status_s;
  logic [31:0] cause_s;
  logic        intreq_s;
  logic        exc_int_s;
  logic        exc_sys_s;
  logic        exc_eret_s;
  logic        wr_en_s;

  assign status_s = {16'h0000, im_q, 6'b000000, exl_q, ie_q};
  assign cause_s  = {16'h0000, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};

  // Exception decode: interrupt beats syscall beats eret, and squashes MTC0
  always_comb begin
    intreq_s   = ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));
    exc_int_s  = intreq_s;
    exc_sys_s  = ~intreq_s & ExcSyscall;
    exc_eret_s = ~intreq_s & ~ExcSyscall & ExcEret;
    wr_en_s    = CP0WE & ~intreq_s;
  end

  // MFC0 read mux and fetch redirect
  always_comb begin
    RData    = 32'h0000_0000;
    ExcTaken = 1'b0;
    ExcPC    = 32'h0000_0000;
    if (CP0RE) begin
      case (CP0RAddr)
        REG_COUNT:   RData = count_q;
        REG_COMPARE: RData = compare_q;
        REG_STATUS:  RData = status_s;
        REG_CAUSE:   RData = cause_s;
        REG_EPC:     RData = epc_q;
        default:     RData = 32'h0000_0000;
      endcase
    end else begin
      RData = 32'h0000_0000;
    end
    if (exc_int_s || exc_sys_s) begin
      ExcTaken = 1'b1;
      ExcPC    = HANDLER_ADDR;
    end else if (exc_eret_s) begin
      ExcTaken = 1'b1;
      ExcPC    = epc_q;
    end else begin
      ExcTaken = 1'b0;
      ExcPC    = 32'h0000_0000;
    end
  end

  // Next-state for the timer, hardware IP sampling and software writes
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    ip_hw_d   = {timer_q | IntIn[5], IntIn[4:0]};
    ip_sw_d   = ip_sw_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    timer_d   = timer_q;

    // A Compare write clears pending and wins over a same-cycle match
    if (wr_en_s && (CP0WAddr == REG_COMPARE)) begin
      timer_d = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'h0000_0000)) begin
      timer_d = 1'b1;
    end else begin
      timer_d = timer_q;
    end

    if (wr_en_s) begin
      case (CP0WAddr)
        REG_COUNT:   count_d   = WData;
        REG_COMPARE: compare_d = WData;
        REG_STATUS: begin
          if (!exc_sys_s && !exc_eret_s) begin
            im_d  = WData[15:8];
            exl_d = WData[1];
            ie_d  = WData[0];
          end else begin
            im_d  = im_q;
          end
        end
        REG_CAUSE:   ip_sw_d   = WData[9:8];
        REG_EPC:     epc_d     = WData;
        default:     count_d   = count_q + 32'd1;
      endcase
    end else begin
      count_d = count_q + 32'd1;
    end

    // Exception side effects are applied last so they override MTC0
    if (exc_int_s) begin
      epc_d     = PC;
      exccode_d = EXC_INT;
      exl_d     = 1'b1;
    end else if (exc_sys_s) begin
      exccode_d = EXC_SYSCALL;
      exl_d     = 1'b1;
      if (!exl_q) begin
        epc_d = PC;
      end else begin
        epc_d = epc_q;
      end
    end else if (exc_eret_s) begin
      exl_d = 1'b0;
    end else begin
      exl_d = exl_d;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 32'h0000_0000;
      compare_q <= 32'h0000_0000;
      im_q      <= 8'h00;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      ip_hw_q   <= 6'b000000;
      ip_sw_q   <= 2'b00;
      exccode_q <= 5'd0;
      epc_q     <= 32'h0000_0000;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      ip_hw_q   <= ip_hw_d;
      ip_sw_q   <= ip_sw_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  assign StatusOut = status_s;
  assign CauseOut  = cause_s;
  assign EPCOut    = epc_q;
  assign TimerInt  = timer_q;

endmodule
